// File: rtl/irda_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irda_pkg : shared types, defaults and frame slot map for the IrDA TX  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package irda_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } irda_state_e;

    localparam int DEF_BIT_CLKS   = 16;
    localparam int DEF_PULSE_CLKS = 3;
    localparam int DEF_NUM_SLOTS  = 12;
    localparam int FRAME_BITS     = 12;

    localparam logic [3:0] SLOT_START  = 4'd0;
    localparam logic [3:0] SLOT_DATA0  = 4'd1;
    localparam logic [3:0] SLOT_PARITY = 4'd9;
    localparam logic [3:0] SLOT_STOP0  = 4'd10;
    localparam logic [3:0] SLOT_STOP1  = 4'd11;

    // Bit value of every slot, slot 0 in bit 0 so the frame can be shifted out LSB first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                          input logic       slot9);
        logic [FRAME_BITS-1:0] f;
        f                  = '1;
        f[SLOT_START]      = 1'b0;
        f[SLOT_DATA0 +: 8] = data;
        f[SLOT_PARITY]     = slot9;
        f[SLOT_STOP0]      = 1'b1;
        f[SLOT_STOP1]      = 1'b1;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irda_pulse_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irda_pulse_timer : per-slot cycle counter and IR pulse window         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module irda_pulse_timer
    import irda_pkg::*;
#(
    parameter int BIT_CLKS   = DEF_BIT_CLKS,
    parameter int PULSE_CLKS = DEF_PULSE_CLKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic slot_end_o,
    output logic pulse_on_o
);

    localparam int            CW   = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] PW   = CW'(PULSE_CLKS);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero while disabled so the first enabled cycle is offset 0 of a slot.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_end_o = en_i & (cnt_q == LAST);
    assign pulse_on_o = en_i & (cnt_q < PW);

endmodule
`default_nettype wire

// File: rtl/irda_txd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irda_txd_ctrl : IrDA SIR frame transmitter driving an external bit    |
// | counter; IRDA_PARITY_EN puts even parity in slot 9.   Rev 1.0         |
// +----------------------------------------------------------------------+
module irda_txd_ctrl
    import irda_pkg::*;
#(
    parameter int BIT_CLKS   = DEF_BIT_CLKS,
    parameter int PULSE_CLKS = DEF_PULSE_CLKS,
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    input  logic       bit_done_i,
    output logic       tx_ack_o,
    output logic       tx_busy_o,
    output logic       bit_clear_o,
    output logic       bit_count_o,
    output logic       irtx_o,
    output logic       tx_done_o,
    output logic       tx_err_o
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_SLOTS);

    irda_state_e           state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  send;
    logic                  slot_end;
    logic                  pulse_on;
    logic                  slot9_bit;

`ifdef IRDA_PARITY_EN
    assign slot9_bit = ^tx_data_i;
`else
    assign slot9_bit = 1'b1;
`endif

    assign send = (state_q == ST_SEND);

    irda_pulse_timer #(
        .BIT_CLKS   (BIT_CLKS),
        .PULSE_CLKS (PULSE_CLKS)
    ) u_pulse_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (send),
        .slot_end_o (slot_end),
        .pulse_on_o (pulse_on)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_start_i) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    shift_d = build_frame(tx_data_i, slot9_bit);
                end
            end
            ST_SEND: begin
                if (slot_end) begin
                    idx_d   = idx_q + 4'd1;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    if (bit_done_i || (idx_d == LAST_IDX)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // The counter is registered, so in DONE it shows the pulses of every slot just sent;
    // a completed frame must see bit_done high exactly when the index reached NUM_SLOTS.
    always_comb begin
        tx_ack_o    = 1'b0;
        tx_busy_o   = 1'b0;
        bit_clear_o = 1'b1;
        bit_count_o = 1'b0;
        irtx_o      = 1'b0;
        tx_done_o   = 1'b0;
        tx_err_o    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_ack_o = tx_start_i & rst_n;
            end
            ST_SEND: begin
                tx_busy_o   = 1'b1;
                bit_clear_o = 1'b0;
                bit_count_o = slot_end;
                irtx_o      = pulse_on & ~shift_q[0];
            end
            ST_DONE: begin
                tx_busy_o = 1'b1;
                tx_done_o = 1'b1;
                tx_err_o  = (idx_q == LAST_IDX) ^ bit_done_i;
            end
            default: begin
                bit_clear_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irda_txd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_irda_txd_ctrl : irda_txd_ctrl paired with a behavioural bit counter|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_irda_txd_ctrl;

    localparam int BC = 16;
    localparam int PC = 3;
    localparam int NS = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       bit_done;
    logic       tx_ack, tx_busy, bit_clear, bit_count, irtx, tx_done, tx_err;
    logic       force_hi = 1'b0;
    logic       force_lo = 1'b0;
    logic [3:0] bc_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    irda_txd_ctrl #(
        .BIT_CLKS   (BC),
        .PULSE_CLKS (PC),
        .NUM_SLOTS  (NS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start_i  (tx_start),
        .tx_data_i   (tx_data),
        .bit_done_i  (bit_done),
        .tx_ack_o    (tx_ack),
        .tx_busy_o   (tx_busy),
        .bit_clear_o (bit_clear),
        .bit_count_o (bit_count),
        .irtx_o      (irtx),
        .tx_done_o   (tx_done),
        .tx_err_o    (tx_err)
    );

    always #5 clk = ~clk;

    // External bit counter: sync clear, count enable, terminal flag at NUM_SLOTS.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         bc_cnt <= 4'd0;
        else if (bit_clear) bc_cnt <= 4'd0;
        else if (bit_count) bc_cnt <= bc_cnt + 4'd1;
    end
    assign bit_done = force_hi | (~force_lo & (bc_cnt == 4'(NS)));

    function automatic logic exp_bit(input int slot, input logic [7:0] d);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (slot == 9) begin
`ifdef IRDA_PARITY_EN
            return ^d;
`else
            return 1'b1;
`endif
        end
        return 1'b1;
    endfunction

    // One frame started at cycle 0, checked cycle by cycle against the slot rules.
    task automatic check_frame(input logic [7:0] d, input int early_at,
                               input bit stuck_lo, input int restart_at);
        int end_c, slot, off, pulses, hi_cyc, cnts, exp_slots, exp_pulses;
        bit send, err_exp, prev_ir;
        logic [6:0] got, exp;
        end_c = NS*BC + 1;
        if (early_at > 0) end_c = ((early_at + BC - 1) / BC) * BC + 1;
        err_exp = stuck_lo || (end_c < NS*BC + 1);
        pulses = 0; hi_cyc = 0; cnts = 0; prev_ir = 1'b0;
        for (int c = 0; c <= end_c + 2; c++) begin
            @(posedge clk); #1;
            tx_start = (c == 0) || (c == restart_at);
            tx_data  = (c == 0) ? d : 8'($urandom);
            force_hi = (early_at > 0) && (c >= early_at) && (c <= end_c);
            force_lo = stuck_lo && (c <= end_c);
            @(negedge clk);
            send = (c >= 1) && (c < end_c);
            slot = (c - 1) / BC;
            off  = (c - 1) % BC;
            exp  = {c == 0, (c >= 1) && (c <= end_c), !send, send && (off == BC-1),
                    send && !exp_bit(slot, d) && (off < PC), c == end_c,
                    (c == end_c) && err_exp};
            got  = {tx_ack, tx_busy, bit_clear, bit_count, irtx, tx_done, tx_err};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL frame d=%02h cyc%0d got=%b exp=%b (ack busy clr cnt ir done err)",
                         d, c, got, exp);
            end
            if (irtx === 1'b1) hi_cyc++;
            if (irtx === 1'b1 && !prev_ir) pulses++;
            if (bit_count === 1'b1) cnts++;
            prev_ir = (irtx === 1'b1);
        end
        tx_start = 1'b0; force_hi = 1'b0; force_lo = 1'b0;
        exp_slots = (end_c - 1) / BC;
        exp_pulses = 0;
        for (int s = 0; s < exp_slots; s++) if (!exp_bit(s, d)) exp_pulses++;
        n_cmp++;
        if (cnts != exp_slots) begin
            n_bad++; $display("FAIL bit_count_pulses d=%02h got=%0d exp=%0d", d, cnts, exp_slots);
        end
        n_cmp++;
        if (pulses != exp_pulses) begin
            n_bad++; $display("FAIL irtx_pulses d=%02h got=%0d exp=%0d", d, pulses, exp_pulses);
        end
        n_cmp++;
        if (hi_cyc != exp_pulses * PC) begin
            n_bad++; $display("FAIL irtx_width d=%02h got=%0d exp=%0d", d, hi_cyc, exp_pulses*PC);
        end
    endtask

    task automatic test_reset;
        logic [6:0] got;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {tx_ack, tx_busy, bit_clear, bit_count, irtx, tx_done, tx_err};
        n_cmp++;
        if (got !== 7'b0010000) begin
            n_bad++; $display("FAIL reset_state got=%b exp=%b", got, 7'b0010000);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_patterns;
        check_frame(8'h00, -1, 1'b0, -1);
        check_frame(8'hFF, -1, 1'b0, -1);
        check_frame(8'hA5, -1, 1'b0, 50);
    endtask

    task automatic test_bitdone_errors;
        check_frame(8'($urandom), 100, 1'b0, -1);
        check_frame(8'($urandom), -1, 1'b1, -1);
        check_frame(8'($urandom), int'($urandom_range(20, 180)), 1'b0, -1);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        logic [2:0] got;
        int dones, busies;
        d = 8'($urandom);
        @(posedge clk); #1 tx_start = 1'b1; tx_data = d;
        @(posedge clk); #1 tx_start = 1'b0;
        repeat (69) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        got = {irtx, tx_busy, bit_clear};
        n_cmp++;
        if (got !== 3'b001) begin
            n_bad++; $display("FAIL async_reset got=%b exp=%b (ir busy clr)", got, 3'b001);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0; busies = 0;
        for (int c = 0; c < 220; c++) begin
            @(negedge clk);
            if (tx_done !== 1'b0) dones++;
            if (tx_busy !== 1'b0) busies++;
        end
        n_cmp++;
        if (dones != 0 || busies != 0) begin
            n_bad++; $display("FAIL abandoned_frame done=%0d busy=%0d exp 0/0", dones, busies);
        end
        check_frame(8'($urandom), -1, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        int ack1, ack2, done1, done2, acks, errs;
        ack1 = -1; ack2 = -1; done1 = -1; done2 = -1; acks = 0; errs = 0;
        @(posedge clk); #1 tx_start = 1'b1; tx_data = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                tx_start = (acks < 2);
                tx_data  = 8'($urandom);
            end
            @(negedge clk);
            if (tx_ack === 1'b1) begin
                acks++;
                if (ack1 < 0) ack1 = c; else if (ack2 < 0) ack2 = c;
            end
            if (tx_done === 1'b1) begin
                if (done1 < 0) done1 = c; else if (done2 < 0) done2 = c;
            end
            if (tx_err !== 1'b0) errs++;
        end
        tx_start = 1'b0;
        n_cmp++;
        if (ack1 != 0 || done1 != NS*BC+1) begin
            n_bad++; $display("FAIL b2b_first ack=%0d done=%0d exp 0/%0d", ack1, done1, NS*BC+1);
        end
        n_cmp++;
        if (ack2 != NS*BC+2 || done2 != 2*NS*BC+3) begin
            n_bad++; $display("FAIL b2b_second ack=%0d done=%0d exp %0d/%0d",
                              ack2, done2, NS*BC+2, 2*NS*BC+3);
        end
        n_cmp++;
        if (acks != 2 || errs != 0) begin
            n_bad++; $display("FAIL b2b_counts acks=%0d errs=%0d exp 2/0", acks, errs);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3; i++)
            check_frame(8'($urandom), -1, 1'b0, int'($urandom_range(1, NS*BC)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_patterns;
        test_bitdone_errors;
        test_reset_midframe;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
